// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR pseudo-random generator: mode encoding,
// default seed and a table of known-maximal tap masks.
package lfsr_pkg;

    typedef enum logic {
        MODE_FIB = 1'b0,
        MODE_GAL = 1'b1
    } lfsr_mode_e;

    localparam logic [31:0] LFSR_SEED_DEFAULT = 32'h0000ACE1;

    // Maximal-length tap masks for the common widths; zero means "no table entry".
    function automatic logic [31:0] lfsr_default_taps(input int unsigned n);
        logic [31:0] taps;
        taps = '0;
        case (n)
            4:       taps = 32'h0000_0009;
            8:       taps = 32'h0000_00B8;
            16:      taps = 32'h0000_B400;
            32:      taps = 32'h8020_0003;
            default: taps = '0;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational single LFSR step in either Fibonacci or Galois form.
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int unsigned     N    = 16,
    parameter logic [N-1:0]    TAPS = 16'hB400
) (
    input  logic [N-1:0] i_s,
    input  lfsr_mode_e   i_mode,
    output logic [N-1:0] o_s
);

    logic w_fb;

    assign w_fb = ^(i_s & TAPS);

    always_comb begin
        o_s = '0;
        if (i_mode == MODE_GAL) begin
            o_s = i_s[0] ? ((i_s >> 1) ^ TAPS) : (i_s >> 1);
        end else begin
            o_s = {i_s[N-2:0], w_fb};
        end
    end

endmodule

// File: rtl/lfsr_prng.sv
// N-bit LFSR generator with seed load, multi-step advance, valid/ready output,
// zero-lockup recovery and a pulse when the sequence returns to its start state.
module lfsr_prng
    import lfsr_pkg::*;
#(
    parameter int unsigned N            = 16,
    parameter logic [31:0] TAPS         = 32'h0000_B400,
    parameter int unsigned STEPS        = 1,
    parameter logic [31:0] SEED_DEFAULT = LFSR_SEED_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         mode,
    input  logic         seed_load,
    input  logic [N-1:0] seed_in,
    input  logic         ready,
    output logic [N-1:0] random,
    output logic         valid,
    output logic         lock_err,
    output logic         wrap
);

    localparam logic [N-1:0] C_TAPS = TAPS[N-1:0];
    localparam logic [N-1:0] C_SEED = SEED_DEFAULT[N-1:0];

    logic [N-1:0] r_state;
    logic [N-1:0] r_start;
    logic         r_valid;
    logic         r_lock_err;
    logic         r_wrap;

    lfsr_mode_e   w_mode;
    logic [N-1:0] w_chain [0:STEPS];
    logic         w_adv;
    logic         w_next_zero;
    logic [N-1:0] w_new;

    assign w_mode     = lfsr_mode_e'(mode);
    assign w_chain[0] = r_state;

    // STEPS single steps collapse into one register update per advance.
    for (genvar g = 0; g < STEPS; g++) begin : g_step
        lfsr_step #(
            .N    (N),
            .TAPS (C_TAPS)
        ) u_step (
            .i_s    (w_chain[g]),
            .i_mode (w_mode),
            .o_s    (w_chain[g+1])
        );
    end

    assign w_adv       = ena && (!r_valid || ready);
    assign w_next_zero = (w_chain[STEPS] == '0);
    assign w_new       = w_next_zero ? C_SEED : w_chain[STEPS];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= C_SEED;
            r_start    <= C_SEED;
            r_valid    <= 1'b0;
            r_lock_err <= 1'b0;
            r_wrap     <= 1'b0;
        end else if (seed_load) begin
            r_state    <= (seed_in == '0) ? C_SEED : seed_in;
            r_start    <= (seed_in == '0) ? C_SEED : seed_in;
            r_lock_err <= (seed_in == '0);
            r_valid    <= 1'b0;
            r_wrap     <= 1'b0;
        end else if (w_adv) begin
            r_state <= w_new;
            r_valid <= 1'b1;
            r_wrap  <= (w_new == r_start);
            if (w_next_zero) begin
                r_lock_err <= 1'b1;
            end
        end else begin
            r_wrap <= 1'b0;
            if (r_valid && ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign random   = r_state;
    assign valid    = r_valid;
    assign lock_err = r_lock_err;
    assign wrap     = r_wrap;

endmodule

// File: tb/tb_lfsr_prng.sv
// Scoreboard bench for lfsr_prng: stimulus pushes hand-computed values, a
// monitor pops and compares them whenever an output word is handed over.
module tb_lfsr_prng;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic        mode;
    logic        seed_load;
    logic [15:0] seed_in;
    logic        ready;

    logic [15:0] random,   random4;
    logic        valid,    valid4;
    logic        lock_err, lock_err4;
    logic        wrap,     wrap4;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [15:0] q1 [$];
    logic [15:0] q4 [$];
    logic        chk_en   = 1'b0;
    logic        chk4_en  = 1'b0;
    logic        seen_mid = 1'b0;

    always #5 clk = ~clk;

    lfsr_prng #(
        .N            (16),
        .TAPS         (32'h0000_B400),
        .STEPS        (1),
        .SEED_DEFAULT (32'h0000_ACE1)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .mode      (mode),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .ready     (ready),
        .random    (random),
        .valid     (valid),
        .lock_err  (lock_err),
        .wrap      (wrap)
    );

    lfsr_prng #(
        .N            (16),
        .TAPS         (32'h0000_B400),
        .STEPS        (4),
        .SEED_DEFAULT (32'h0000_ACE1)
    ) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .mode      (mode),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .ready     (ready),
        .random    (random4),
        .valid     (valid4),
        .lock_err  (lock_err4),
        .wrap      (wrap4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_seed(input logic [15:0] v);
        seed_load = 1'b1;
        seed_in   = v;
        tick();
        seed_load = 1'b0;
    endtask

    // One accepted advance, then one idle cycle in which the word is consumed.
    task automatic advance_once();
        ena = 1'b1;
        tick();
        ena = 1'b0;
        tick();
    endtask

    always @(negedge clk) begin
        if (chk_en && valid && ready) begin
            if (q1.size() == 0) begin
                check("sb_unexpected_word", {16'h0, random}, 32'hFFFF_FFFF);
            end else begin
                check("sb_random", {16'h0, random}, {16'h0, q1.pop_front()});
            end
        end
        if (chk4_en) begin
            if (random4 == 16'hB400 || random4 == 16'h5A00 || random4 == 16'h2D00) begin
                seen_mid = 1'b1;
            end
            if (valid4 && ready) begin
                if (q4.size() == 0) begin
                    check("sb4_unexpected_word", {16'h0, random4}, 32'hFFFF_FFFF);
                end else begin
                    check("sb4_random", {16'h0, random4}, {16'h0, q4.pop_front()});
                end
            end
        end
    end

    initial begin
        int unsigned first_wrap;
        logic        early_wrap;
        logic [15:0] wrap_val;

        rst       = 1'b0;
        ena       = 1'b0;
        mode      = 1'b0;
        seed_load = 1'b0;
        seed_in   = '0;
        ready     = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("reset_random",   {16'h0, random}, 32'h0000_ACE1);
        check("reset_valid",    {31'h0, valid},  32'h0);
        check("reset_lock_err", {31'h0, lock_err}, 32'h0);
        check("reset_wrap",     {31'h0, wrap},   32'h0);

        chk_en = 1'b1;
        ready  = 1'b1;

        // Galois steps
        mode = 1'b1;
        load_seed(16'hACE1);
        q1.push_back(16'hE270);
        ena = 1'b1;
        tick();
        ena = 1'b0;
        check("galois_wrap_low", {31'h0, wrap}, 32'h0);
        tick();
        check("consume_valid_drop", {31'h0, valid}, 32'h0);

        load_seed(16'h0001);
        q1.push_back(16'hB400);
        advance_once();

        // Fibonacci steps
        mode = 1'b0;
        load_seed(16'h0001);
        q1.push_back(16'h0002);
        advance_once();
        load_seed(16'h8000);
        q1.push_back(16'h0001);
        advance_once();

        // Four chained Galois steps in the STEPS=4 instance
        mode = 1'b1;
        load_seed(16'h0001);
        chk4_en = 1'b1;
        q1.push_back(16'hB400);
        q4.push_back(16'h1680);
        advance_once();
        chk4_en = 1'b0;
        check("steps4_no_intermediate", {31'h0, seen_mid}, 32'h0);

        // Backpressure holds the word regardless of ena
        ready = 1'b0;
        load_seed(16'h0001);
        q1.push_back(16'hB400);
        ena = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            check("backpressure_hold", {16'h0, random}, 32'h0000_B400);
        end
        ena   = 1'b0;
        ready = 1'b1;
        tick();
        check("backpressure_release_valid", {31'h0, valid}, 32'h0);

        // Zero seed replaced by default; then a full period
        chk_en = 1'b0;
        load_seed(16'h0000);
        check("zero_seed_random",   {16'h0, random},   32'h0000_ACE1);
        check("zero_seed_lock_err", {31'h0, lock_err}, 32'h1);
        check("zero_seed_valid",    {31'h0, valid},    32'h0);

        first_wrap = 0;
        early_wrap = 1'b0;
        wrap_val   = '0;
        ena        = 1'b1;
        for (int unsigned i = 1; i <= 70000; i++) begin
            tick();
            if (wrap) begin
                if (i < 65535) early_wrap = 1'b1;
                if (first_wrap == 0) begin
                    first_wrap = i;
                    wrap_val   = random;
                end
            end
            if (first_wrap != 0) break;
        end
        ena = 1'b0;
        check("period_no_early_wrap", {31'h0, early_wrap}, 32'h0);
        check("period_wrap_count",    first_wrap,          32'd65535);
        check("period_wrap_state",    {16'h0, wrap_val},   32'h0000_ACE1);
        tick();
        check("wrap_single_pulse",    {31'h0, wrap},       32'h0);
        check("lock_err_sticky",      {31'h0, lock_err},   32'h1);

        load_seed(16'h1234);
        check("lock_err_cleared", {31'h0, lock_err}, 32'h0);

        // Mid-operation reset with a word pending
        ready = 1'b0;
        ena   = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        ena = 1'b0;
        check("midreset_random",   {16'h0, random},   32'h0000_ACE1);
        check("midreset_valid",    {31'h0, valid},    32'h0);
        check("midreset_lock_err", {31'h0, lock_err}, 32'h0);

        check("sb_queue_drained",  q1.size(), 32'd0);
        check("sb4_queue_drained", q4.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lfsr_prng.md
Name: lfsr_prng

Overview:
Parametrised successor to the single-width LFSR generator: N-bit LFSR with selectable Fibonacci/Galois mode, runtime seed load, configurable bits-advanced-per-enable (STEPS), valid/ready output handshake, zero-lockup recovery and a period-wrap pulse.
Sits between the on-chip entropy/seed source and the consumers (masking, nonce and key-stream blocks) in the crypto/side-channel test designs.

Parameters:
N, 16, LFSR width in bits (legal 3..32)
TAPS, 16'hB400, tap mask; bit i set means x^(i+1) is in the polynomial (default x^16+x^14+x^13+x^11+1, maximal)
STEPS, 1, single-steps applied per accepted advance (legal 1..N)
SEED_DEFAULT, 16'hACE1, reset and lockup-recovery state (must be non-zero)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  reset: one clock domain, synchronous, active-low (rst==0 at posedge resets)
ena  in  1  request to advance the LFSR
mode  in  1  0 = Fibonacci, 1 = Galois; sampled on each advance
seed_load  in  1  load seed_in this cycle
seed_in  in  N  seed value
ready  in  1  consumer accepts random this cycle
random  out  N  current LFSR state (registered)
valid  out  1  random holds a fresh, unconsumed value
lock_err  out  1  sticky: a zero state was loaded or computed and was replaced
wrap  out  1  one-cycle pulse: the newly advanced state equals the last loaded start state

Behaviour:
- Priority per cycle: reset > seed_load > advance > consume.
- Reset: state=SEED_DEFAULT, start=SEED_DEFAULT, valid=0, lock_err=0, wrap=0. Mid-operation reset discards everything next edge.
- Fibonacci single step: fb = ^(s & TAPS); s' = {s[N-2:0], fb}.
- Galois single step: s' = s[0] ? ((s>>1) ^ TAPS) : (s>>1).
- Advance: STEPS single steps chained combinationally, one register update. No intermediate states visible.
- seed_load: state=start=(seed_in==0 ? SEED_DEFAULT : seed_in). lock_err set if seed_in==0, cleared if non-zero. valid=0, wrap=0. A simultaneous ena is ignored.
- Advance accepted when ena && (!valid || ready). Next edge: random=new state, valid=1. Latency one cycle. Supports back-to-back advances at full rate.
- Backpressure: valid && !ready means state and random hold regardless of ena.
- Consume without refill (valid && ready && !ena): valid=0, state held.
- Runtime zero guard: if the computed next state is 0 (bad TAPS), load SEED_DEFAULT and set lock_err.
- wrap=1 for exactly the cycle after an advance whose result equals start; otherwise 0. Only post-advance states are compared.
- Mode change takes effect on the next advance. Start is not reset by a mode change.
- Widths: all state arithmetic is N bits. TAPS and SEED_DEFAULT are truncated to N.

Decomposition:
- Package lfsr_pkg holds:
  - MODE_FIB=1'b0 and MODE_GAL=1'b1
  - default taps table for N=4,8,16,32 (4'h9, 8'hB8, 16'hB400, 32'h80200003)
  - SEED_DEFAULT value
- Sub-module lfsr_step: combinational single step (s, mode, TAPS to s'). Instantiated STEPS times in a generate chain.

Test Plan:
- Reset with N=16, then release → random=16'hACE1, valid=0, lock_err=0, wrap=0.
- Galois step: seed_load 16'hACE1, one ena → random=16'hE270, valid=1. Seed 16'h0001, one ena → 16'hB400.
- Fibonacci step: seed 16'h0001, mode=0, ena → 16'h0002. Then seed 16'h8000, ena → 16'h0001.
- STEPS=4, Galois, seed 16'h0001, one ena → 16'h1680. Intermediate values B400, 5A00, 2D00 are never output.
- Backpressure: valid=1, ready=0, ena=1 for 10 cycles → random constant. Then ready=1, ena=0 → valid drops next cycle.
- Zero seed and period: seed_load 0 → random=16'hACE1, lock_err=1. Continuous ena/ready, Galois → wrap pulses exactly after 65535 advances, and never earlier.
